// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared opcodes, state enum and control word layout for the SAP-1 controller
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_e;

    // Field order matches the conventional SAP-1 control word, MSB first
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_bar;
        logic ce_bar;
        logic li_bar;
        logic ei_bar;
        logic la_bar;
        logic ea;
        logic su;
        logic eu;
        logic lb_bar;
        logic lo_bar;
    } control_word_t;

    // Every load/enable inactive: active-low strobes high, active-high ones low
    localparam control_word_t CW_IDLE = 12'b0011_1110_0011;

    // Map the one-hot ring plus halt flag onto a named state for decode
    function automatic state_e ring_to_state(input logic [5:0] ring, input logic halted);
        state_e s;
        s = ST_T1;
        if (halted)        s = ST_HALT;
        else if (ring[1])  s = ST_T2;
        else if (ring[2])  s = ST_T3;
        else if (ring[3])  s = ST_T4;
        else if (ring[4])  s = ST_T5;
        else if (ring[5])  s = ST_T6;
        return s;
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// rtl/sap1_ring_counter.sv - six-state one-hot ring counter stepping on the falling clock edge
module sap1_ring_counter (
    input  logic       clk,
    input  logic       clr,
    input  logic       hold,
    output logic [5:0] ring
);

    logic [5:0] ring_q;
    logic [5:0] ring_d;

    // Rotate T1->T6->T1 unless held by the halt logic
    always_comb begin
        ring_d = hold ? ring_q : {ring_q[4:0], ring_q[5]};
    end

    // Falling-edge state so datapath registers see stable controls on the rising edge
    always_ff @(negedge clk or posedge clr) begin
        if (clr) ring_q <= 6'b000001;
        else     ring_q <= ring_d;
    end

    assign ring = ring_q;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// rtl/sap1_controller_sequencer.sv - SAP-1 control unit: ring counter, halt latch and control word decode
module sap1_controller_sequencer
    import sap1_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic [OPCODE_W-1:0] instr_in,
    output logic                Cp,
    output logic                Ep,
    output logic                Lm_bar,
    output logic                CE_bar,
    output logic                Li_bar,
    output logic                Ei_bar,
    output logic                La_bar,
    output logic                Ea,
    output logic                Su,
    output logic                Eu,
    output logic                Lb_bar,
    output logic                Lo_bar,
    output logic                hlt,
    output logic [5:0]          t_state
);

    logic [5:0]    ring;
    logic          hlt_q;
    logic          hlt_d;
    state_e        state;
    control_word_t cw;

    // HLT is recognised only on the edge leaving T3; once set it sticks until CLR
    always_comb begin
        hlt_d = hlt_q | (ring[2] & (instr_in == OPCODE_W'(OP_HLT)));
    end

    // Halt latch shares the ring's falling edge so it replaces the T3->T4 step
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) hlt_q <= 1'b0;
        else     hlt_q <= hlt_d;
    end

    // Hold on hlt_d so the ring never advances on the edge that enters HALT
    sap1_ring_counter u_ring (
        .clk  (CLK),
        .clr  (CLR),
        .hold (hlt_d),
        .ring (ring)
    );

    assign state = ring_to_state(ring, hlt_q);

    // Control word decode; CLR and HALT both force the idle word
    always_comb begin
        cw = CW_IDLE;
        if (!CLR) begin
            unique case (state)
                ST_T1: begin
                    cw.ep     = 1'b1;
                    cw.lm_bar = 1'b0;
                end
                ST_T2: cw.cp = 1'b1;
                ST_T3: begin
                    cw.ce_bar = 1'b0;
                    cw.li_bar = 1'b0;
                end
                ST_T4: begin
                    if (instr_in == OPCODE_W'(OP_LDA) || instr_in == OPCODE_W'(OP_ADD) ||
                        instr_in == OPCODE_W'(OP_SUB)) begin
                        cw.lm_bar = 1'b0;
                        cw.ei_bar = 1'b0;
                    end else if (instr_in == OPCODE_W'(OP_OUT)) begin
                        cw.ea     = 1'b1;
                        cw.lo_bar = 1'b0;
                    end
                end
                ST_T5: begin
                    if (instr_in == OPCODE_W'(OP_LDA)) begin
                        cw.ce_bar = 1'b0;
                        cw.la_bar = 1'b0;
                    end else if (instr_in == OPCODE_W'(OP_ADD) || instr_in == OPCODE_W'(OP_SUB)) begin
                        cw.ce_bar = 1'b0;
                        cw.lb_bar = 1'b0;
                    end
                end
                ST_T6: begin
                    if (instr_in == OPCODE_W'(OP_ADD) || instr_in == OPCODE_W'(OP_SUB)) begin
                        cw.eu     = 1'b1;
                        cw.la_bar = 1'b0;
                        cw.su     = (instr_in == OPCODE_W'(OP_SUB));
                    end
                end
                default: cw = CW_IDLE;
            endcase
        end
    end

    assign Cp      = cw.cp;
    assign Ep      = cw.ep;
    assign Lm_bar  = cw.lm_bar;
    assign CE_bar  = cw.ce_bar;
    assign Li_bar  = cw.li_bar;
    assign Ei_bar  = cw.ei_bar;
    assign La_bar  = cw.la_bar;
    assign Ea      = cw.ea;
    assign Su      = cw.su;
    assign Eu      = cw.eu;
    assign Lb_bar  = cw.lb_bar;
    assign Lo_bar  = cw.lo_bar;
    assign hlt     = hlt_q;
    assign t_state = hlt_q ? 6'b000000 : ring;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// tb/tb_sap1_controller_sequencer.sv - scoreboard bench for the SAP-1 controller sequencer
module tb_sap1_controller_sequencer;

    localparam logic [11:0] W_IDLE   = 12'b0011_1110_0011;
    localparam logic [11:0] W_T1     = 12'b0101_1110_0011;
    localparam logic [11:0] W_T2     = 12'b1011_1110_0011;
    localparam logic [11:0] W_T3     = 12'b0010_0110_0011;
    localparam logic [11:0] W_T4_MEM = 12'b0001_1010_0011;
    localparam logic [11:0] W_T4_OUT = 12'b0011_1111_0010;
    localparam logic [11:0] W_T5_LDA = 12'b0010_1100_0011;
    localparam logic [11:0] W_T5_B   = 12'b0010_1110_0001;
    localparam logic [11:0] W_T6_ADD = 12'b0011_1100_0111;
    localparam logic [11:0] W_T6_SUB = 12'b0011_1100_1111;

    logic       CLK;
    logic       CLR;
    logic [3:0] instr_in;
    logic       Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar;
    logic       hlt;
    logic [5:0] t_state;

    sap1_controller_sequencer #(.OPCODE_W(4)) dut (
        .CLK(CLK), .CLR(CLR), .instr_in(instr_in),
        .Cp(Cp), .Ep(Ep), .Lm_bar(Lm_bar), .CE_bar(CE_bar), .Li_bar(Li_bar),
        .Ei_bar(Ei_bar), .La_bar(La_bar), .Ea(Ea), .Su(Su), .Eu(Eu),
        .Lb_bar(Lb_bar), .Lo_bar(Lo_bar), .hlt(hlt), .t_state(t_state)
    );

    typedef struct {
        string       tag;
        logic [5:0]  t;
        logic        h;
        logic [11:0] cw;
    } exp_t;

    exp_t exp_q[$];
    event mon_ev;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    function automatic logic [11:0] exp_cw(input int s, input logic [3:0] op);
        case (s)
            0: return W_T1;
            1: return W_T2;
            2: return W_T3;
            3: return (op == 4'h0 || op == 4'h1 || op == 4'h2) ? W_T4_MEM :
                      (op == 4'hE) ? W_T4_OUT : W_IDLE;
            4: return (op == 4'h0) ? W_T5_LDA :
                      (op == 4'h1 || op == 4'h2) ? W_T5_B : W_IDLE;
            5: return (op == 4'h1) ? W_T6_ADD : (op == 4'h2) ? W_T6_SUB : W_IDLE;
            default: return W_IDLE;
        endcase
    endfunction

    function automatic logic [5:0] onehot(input int s);
        logic [5:0] v;
        v = 6'b000001 << s;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [5:0] t, input logic h, input logic [11:0] cw);
        exp_t e;
        e.tag = tag;
        e.t   = t;
        e.h   = h;
        e.cw  = cw;
        exp_q.push_back(e);
        ->mon_ev;
    endtask

    task automatic next_state();
        @(negedge CLK);
        #2;
    endtask

    // Walks T2..T6 and back to T1 for one instruction; caller is already in T1
    task automatic run_instr(input string tag, input logic [3:0] op);
        instr_in = op;
        for (int s = 1; s < 6; s++) begin
            next_state();
            chk(tag, onehot(s), 1'b0, exp_cw(s, op));
        end
        next_state();
        chk(tag, onehot(0), 1'b0, W_T1);
    endtask

    // Scoreboard monitor: pops and compares whatever the stimulus queued
    initial begin
        exp_t e;
        logic [11:0] act_cw;
        forever begin
            @(mon_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act_cw = {Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar};
                n_tests++;
                if (t_state !== e.t) begin
                    n_fail++;
                    $display("FAIL %s t_state: got %b expected %b at %0t", e.tag, t_state, e.t, $time);
                end
                n_tests++;
                if (hlt !== e.h) begin
                    n_fail++;
                    $display("FAIL %s hlt: got %b expected %b at %0t", e.tag, hlt, e.h, $time);
                end
                n_tests++;
                if (act_cw !== e.cw) begin
                    n_fail++;
                    $display("FAIL %s control word: got %b expected %b at %0t", e.tag, act_cw, e.cw, $time);
                end
            end
        end
    end

    // At most one bus driver at any rising edge
    always @(posedge CLK) begin
        n_tests++;
        if ($countones({Ep, ~CE_bar, ~Ei_bar, Ea, Eu}) > 1) begin
            n_fail++;
            $display("FAIL bus_exclusive: drivers Ep,CE,Ei,Ea,Eu=%b expected at most one at %0t",
                     {Ep, ~CE_bar, ~Ei_bar, Ea, Eu}, $time);
        end
    end

    initial begin
        logic [3:0] op;
        CLR      = 1'b1;
        instr_in = 4'h0;

        #5  chk("reset", 6'b000001, 1'b0, W_IDLE);
        #50 chk("reset_after_edge", 6'b000001, 1'b0, W_IDLE);
        #55 CLR = 1'b0;
        #2  chk("release_t1", 6'b000001, 1'b0, W_T1);

        for (int k = 1; k <= 6; k++) begin
            next_state();
            chk("lda_ring", onehot(k % 6), 1'b0, exp_cw(k % 6, 4'h0));
        end

        run_instr("add", 4'h1);
        run_instr("sub", 4'h2);
        run_instr("out", 4'hE);
        run_instr("undef5", 4'h5);

        // HLT opcode seen at the T3->T4 edge
        instr_in = 4'hF;
        next_state();
        chk("hlt_t2", 6'b000010, 1'b0, W_T2);
        next_state();
        chk("hlt_t3", 6'b000100, 1'b0, W_T3);
        next_state();
        chk("halt_enter", 6'b000000, 1'b1, W_IDLE);
        for (int k = 0; k < 20; k++) begin
            instr_in = 4'(k);
            next_state();
            chk("halt_hold", 6'b000000, 1'b1, W_IDLE);
        end
        CLR = 1'b1;
        #2 chk("halt_clr", 6'b000001, 1'b0, W_IDLE);
        #3 CLR = 1'b0;
        #1 chk("halt_exit_t1", 6'b000001, 1'b0, W_T1);

        // Async abort in T5 of ADD, before any further falling edge
        instr_in = 4'h1;
        for (int s = 1; s <= 4; s++) begin
            next_state();
            chk("abort_walk", onehot(s), 1'b0, exp_cw(s, 4'h1));
        end
        #3 CLR = 1'b1;
        #1 chk("abort_mid_t5", 6'b000001, 1'b0, W_IDLE);
        #2 CLR = 1'b0;
        #1 chk("abort_release", 6'b000001, 1'b0, W_T1);

        // Opcode changes in T1..T3 (even to HLT) must not matter
        for (int i = 0; i < 200; i++) begin
            op = (i == 0) ? 4'h5 : 4'($urandom_range(0, 14));
            instr_in = 4'($urandom_range(0, 15));
            next_state();
            chk("rand_t2", 6'b000010, 1'b0, W_T2);
            instr_in = 4'($urandom_range(0, 15));
            next_state();
            chk("rand_t3", 6'b000100, 1'b0, W_T3);
            instr_in = op;
            for (int s = 3; s < 6; s++) begin
                next_state();
                chk("rand_exec", onehot(s), 1'b0, exp_cw(s, op));
            end
            next_state();
            chk("rand_t1", 6'b000001, 1'b0, W_T1);
        end

        #5;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sap1_controller_sequencer.md
Name: sap1_controller_sequencer

Overview:
Control unit for the SAP-1 datapath. A six-state ring counter (T1..T6) combines with the opcode from the instruction register to drive the 12-bit control word. The control word sequences the program counter, MAR, RAM, instruction register, accumulator, ALU, B register and output register through fetch and execute. It also halts the machine on HLT.

Parameters:
OPCODE_W, 4, width of instr_in (upper nibble of the instruction register).

Ports:
CLK  input  1  system clock; ring counter advances on the falling edge.
CLR  input  1  asynchronous, active-high reset; forces T1, clears halt.
instr_in  input  OPCODE_W  opcode from instruction register.
Cp  output  1  PC increment (active high).
Ep  output  1  PC enable onto W bus (active high).
Lm_bar  output  1  MAR load (active low).
CE_bar  output  1  RAM enable onto bus (active low).
Li_bar  output  1  IR load (active low).
Ei_bar  output  1  IR address-nibble enable onto bus (active low).
La_bar  output  1  accumulator load (active low).
Ea  output  1  accumulator enable onto bus (active high).
Su  output  1  ALU subtract select (1 = subtract).
Eu  output  1  ALU enable onto bus (active high).
Lb_bar  output  1  B register load (active low).
Lo_bar  output  1  output register load (active low).
hlt  output  1  machine halted; also gates the clock elsewhere.
t_state  output  6  one-hot ring state; bit0 = T1.

Behaviour:
- Reset (CLR=1, asynchronous)
  - State = T1, t_state = 6'b000001, hlt = 0.
  - All control outputs are forced inactive: Cp=Ep=Ea=Su=Eu=0, all *_bar = 1.
  - The T1 word is not driven during CLR.
  - CLR asserted mid-instruction aborts it immediately; there is no partial completion.
- Ring counter
  - Advances one state on each falling CLK edge while CLR=0 and hlt=0: T1->T2->...->T6->T1.
  - One instruction = 6 CLK cycles. Datapath registers load on the rising edge mid-state.
- Control word
  - Combinational from state and instr_in. Unlisted signals are inactive.
  - T1 (address): Ep=1, Lm_bar=0.
  - T2 (increment): Cp=1.
  - T3 (memory): CE_bar=0, Li_bar=0.
  - LDA (4'h0):
    - T4: Lm_bar=0, Ei_bar=0.
    - T5: CE_bar=0, La_bar=0.
    - T6: nop.
  - ADD (4'h1):
    - T4: Lm_bar=0, Ei_bar=0.
    - T5: CE_bar=0, Lb_bar=0.
    - T6: Eu=1, La_bar=0, Su=0.
  - SUB (4'h2): as ADD, but Su=1 in T6. Su is 0 in every other state and opcode.
  - OUT (4'hE):
    - T4: Ea=1, Lo_bar=0.
    - T5, T6: nop.
  - Undefined opcodes: T4..T6 are nop; the ring still cycles normally.
- Halt
  - On the falling edge leaving T3, if instr_in == 4'hF, the controller enters HALT instead of T4.
  - In HALT: hlt=1, t_state=6'b000000, all controls inactive. Falling edges are ignored.
  - Only CLR exits HALT, returning to T1.
- Bus exclusivity: at most one of Ep, ~CE_bar, ~Ei_bar, Ea, Eu is asserted in any state.
- instr_in is sampled only in T4..T6 and at the T3->T4 transition. Changes in T1..T3 have no effect.

Decomposition:
- Shared package sap1_pkg:
  - Opcode localparams OP_LDA=4'h0, OP_ADD=4'h1, OP_SUB=4'h2, OP_OUT=4'hE, OP_HLT=4'hF.
  - typedef enum for T1..T6 plus HALT.
  - Packed struct control_word_t in bit order Cp Ep Lm_bar CE_bar Li_bar Ei_bar La_bar Ea Su Eu Lb_bar Lo_bar.
  - Constant CW_IDLE = 12'b0011_1110_0011.
- One sub-module, sap1_ring_counter: 6-state one-hot counter, negedge clocked, asynchronous CLR, with a hold input driven by the halt state. The decode stays in the top module.

Test Plan:
- CLR=1 at time 0, released after 110 ns with instr_in=4'h0 -> during CLR the control word = CW_IDLE, t_state=000001; after release, T1 shows Ep=1, Lm_bar=0; falling edges step t_state 000010, 000100, ..., back to 000001 after 6 edges.
- instr_in=4'h1 (ADD) -> T4 {Lm_bar,Ei_bar}=00; T5 {CE_bar,Lb_bar}=00; T6 Eu=1, La_bar=0, Su=0.
- instr_in=4'h2 (SUB) -> same as ADD with Su=1 only in T6; instr_in=4'hE -> T4 Ea=1, Lo_bar=0; T5 and T6 = CW_IDLE.
- instr_in=4'hF at the T3->T4 edge -> hlt=1, t_state=000000, control = CW_IDLE for 20 further clocks; then CLR pulse -> hlt=0, T1.
- CLR asserted asynchronously mid-T5 of ADD -> within the same delta, t_state=000001 and control = CW_IDLE, with no falling edge required.
- Random opcodes including 4'h5 over 200 instructions -> bus-exclusivity assertion never fires; undefined opcodes give CW_IDLE in T4..T6.
